usb_tx_fmt: RTL
===============

// Module: usb_tx_fmt
// PURPOSE
//  Device-side TX packet formatter: the consumer of the transaction engine's TX packet interface
//  (start/pid/len/data/data_ack/done). Serialises PID byte, payload fetched from EP buffer, and CRC16
//  as an LSB-first bit stream to the low-level TX layer (NRZI/bit-stuff/SYNC/EOP live downstream).
// PARAMETERS
//  none (length width fixed at 10 bits = max 1023-byte payload)
// PORTS
//  clk            in   1   system clock (48 MHz)
//  rst_n          in   1   reset, synchronous, active-low
//  pkt_start      in   1   1-cycle pulse: begin packet, pkt_pid/pkt_len valid this cycle
//  pkt_pid        in   4   PID to send
//  pkt_len        in   10  payload byte count (DATAx only)
//  pkt_data       in   8   current payload byte from buffer RAM
//  pkt_data_ack   out  1   1-cycle pulse: pkt_data consumed, advance buffer address
//  pkt_done       out  1   1-cycle pulse: packet fully handed to low-level layer
//  ll_start       out  1   1-cycle pulse: open packet (low layer emits SYNC)
//  ll_bit         out  1   current bit to transmit
//  ll_last        out  1   ll_bit is final bit of packet (low layer emits EOP after it)
//  ll_ack         in   1   1-cycle pulse: ll_bit consumed
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): FSM->IDLE; pkt_data_ack, pkt_done, ll_start, ll_bit, ll_last = 0;
//    counters/CRC cleared. Reset mid-packet aborts silently: no pkt_done, no further ll_* activity.
//  - FSM: IDLE -> PID -> [DATA -> CRC] -> IDLE.
//    IDLE: on pkt_start latch pid/len, load shift reg {~pid,pid}, pulse ll_start next cycle, go PID.
//    pkt_start outside IDLE is ignored (no effect on state or latched values).
//  - Packet class from pid[1:0]: 2'b11 (DATAx) = PID+payload+CRC16; any other = PID byte only.
//  - Bit handshake: ll_bit = shift_reg[0]; on ll_ack shift right, bit counter +1; new bit valid the
//    cycle after ll_ack. ll_bit/ll_last held stable while ll_ack low (indefinite stall allowed).
//  - PID: after 8th ll_ack -> DATA if DATAx and len!=0, CRC if DATAx and len==0, else done.
//  - DATA: byte load = shift_reg<=pkt_data with pkt_data_ack pulsed in the same cycle. First load occurs
//    2 cycles after pkt_start (pkt_data valid from then); each later load in the cycle after the 8th
//    ll_ack of the previous byte. Upstream contract: next byte valid 1 cycle after pkt_data_ack.
//    Exactly pkt_len acks per packet. 10-bit byte down-counter; after last byte's 8th ll_ack -> CRC.
//  - CRC16: poly 0x8005, init 0xFFFF, updated bit-serially on each ll_ack of a payload bit (LSB first);
//    CRC state transmitted inverted, 16 bits, bit 15 of CRC register first (= USB wire order).
//    Zero-length DATAx sends CRC bytes 0x00 0x00.
//  - ll_last = 1 while presenting final bit (8th PID bit for non-DATA, 16th CRC bit for DATA).
//  - pkt_done pulses the cycle after ll_ack of the ll_last bit; FSM back in IDLE that same cycle, so
//    pkt_start accepted from then.
//  - ll_ack while IDLE is ignored. pkt_len sampled only at pkt_start.
// STRUCTURE
//  - PID_* constants and PID class decoding come from shared usb_defs.vh (no local copies).
//  - Sub-module usb_crc16: bit-serial CRC (ports clk, rst_n, clr, stb, bit, crc[15:0]); reused by RX side.
//  - Remainder: FSM, 8-bit shift reg, 3-bit bit counter, 10-bit byte counter, 4 bits latched PID.
// TESTING
//  1. ACK (pid=0x2), ll_ack every 4 cycles -> ll_start 1 pulse; bits of 0xD2 LSB-first 0,1,0,0,1,0,1,1;
//     ll_last only on 8th; pkt_done 1 cycle after 8th ack; zero pkt_data_ack.
//  2. DATA0 len=0 (pid=0x3) -> wire bytes C3 00 00 (24 bits), ll_last on bit 24, zero pkt_data_ack.
//  3. DATA1 len=4 payload 00 01 02 03 (pid=0xB) -> bytes 4B 00 01 02 03 + CRC matching bench model;
//     exactly 4 pkt_data_ack, first at pkt_start+2, buffer model returns next byte 1 cycle after ack.
//  4. Random ll_ack stalls (0-20 cycles) on 1023-byte DATA0 -> ll_bit stable during stall, 1023 acks,
//     CRC matches model; byte counter wrap-free.
//  5. pkt_start re-pulsed mid-packet with different pid/len -> ignored, original packet intact.
//  6. rst_n low for 1 cycle mid-DATA -> all outputs 0 next cycle, no pkt_done; fresh ACK then sends OK.

Source files
------------

// File: rtl/usb_tx_fmt_pkg.sv
// Shared definitions for the USB TX packet formatter: PID values, CRC16
// constants, FSM state encoding and the DATAx class decoder.
`timescale 1ns/1ps
package usb_tx_fmt_pkg;

   localparam logic [3:0] PID_ACK   = 4'h2;
   localparam logic [3:0] PID_NAK   = 4'hA;
   localparam logic [3:0] PID_DATA0 = 4'h3;
   localparam logic [3:0] PID_DATA1 = 4'hB;
   localparam logic [3:0] PID_DATA2 = 4'h7;
   localparam logic [3:0] PID_MDATA = 4'hF;

   localparam logic [15:0] CRC16_POLY = 16'h8005;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   localparam int LEN_W = 10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PID,
      ST_DATA,
      ST_CRC
   } tx_state_e;

   // DATAx packets carry payload + CRC16; every other PID is sent as a lone byte.
   function automatic logic pid_is_data(input logic [3:0] pid);
      logic is_data;
      unique case (pid)
         PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: is_data = 1'b1;
         default:                                    is_data = 1'b0;
      endcase
      return is_data;
   endfunction

endpackage

// File: rtl/usb_crc16.sv
// Bit-serial USB CRC16 (poly 0x8005, init 0xFFFF), MSB-first register form.
// Shared between the TX formatter and the RX checker.
`timescale 1ns/1ps
module usb_crc16
   import usb_tx_fmt_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        stb,
   input  logic        bit_in,
   output logic [15:0] crc
);

   logic [15:0] crc_q, crc_d;

   // Next CRC state: clear wins, otherwise fold in one bit per strobe.
   always_comb begin
      crc_d = crc_q;
      if (clr) begin
         crc_d = CRC16_INIT;
      end else if (stb) begin
         crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ bit_in) ? CRC16_POLY : 16'h0000);
      end
   end

   // CRC register.
   always_ff @(posedge clk) begin
      if (!rst_n) crc_q <= CRC16_INIT;
      else        crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/usb_tx_fmt.sv
// USB TX packet formatter: serialises PID, payload and CRC16 LSB-first to the
// low-level TX layer using a one-bit ll_bit/ll_ack handshake.
// Payload is prefetched one byte ahead into hold_q so the next byte is ready
// the moment the current one finishes shifting.
`timescale 1ns/1ps
module usb_tx_fmt
   import usb_tx_fmt_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pkt_start,
   input  logic [3:0]       pkt_pid,
   input  logic [LEN_W-1:0] pkt_len,
   input  logic [7:0]       pkt_data,
   output logic             pkt_data_ack,
   output logic             pkt_done,
   output logic             ll_start,
   output logic             ll_bit,
   output logic             ll_last,
   input  logic             ll_ack
);

   tx_state_e        state_q, state_d;
   logic [7:0]       sr_q, sr_d;
   logic [7:0]       hold_q, hold_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [3:0]       pid_q, pid_d;
   logic             ll_start_q, ll_start_d;
   logic             ack_q, ack_d;
   logic             done_q, done_d;
   logic             crc_clr, crc_stb;
   logic [15:0]      crc;
   logic [3:0]       crc_idx;
   logic             is_data;

   assign is_data = pid_is_data(pid_q);

   usb_crc16 u_crc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (crc_clr),
      .stb    (crc_stb),
      .bit_in (sr_q[0]),
      .crc    (crc)
   );

   // Next-state, shifting, byte fetch and CRC control.
   // byte_cnt_q counts payload bytes not yet moved into the shift register;
   // in ST_CRC its bit 0 selects the low CRC byte.
   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      hold_d     = hold_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      pid_d      = pid_q;
      ll_start_d = 1'b0;
      ack_d      = 1'b0;
      done_d     = 1'b0;
      crc_clr    = 1'b0;
      crc_stb    = 1'b0;

      if (ack_q) hold_d = pkt_data;

      unique case (state_q)
         ST_IDLE: begin
            if (pkt_start) begin
               pid_d      = pkt_pid;
               byte_cnt_d = pkt_len;
               sr_d       = {~pkt_pid, pkt_pid};
               bit_cnt_d  = 3'd0;
               ll_start_d = 1'b1;
               crc_clr    = 1'b1;
               state_d    = ST_PID;
            end
         end
         ST_PID: begin
            // First payload fetch two cycles after pkt_start.
            if (ll_start_q && is_data && (byte_cnt_q != '0)) ack_d = 1'b1;
            if (ll_ack) begin
               sr_d      = {1'b0, sr_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (!is_data) begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else if (byte_cnt_q != '0) begin
                     sr_d       = hold_q;
                     byte_cnt_d = byte_cnt_q - 10'd1;
                     ack_d      = (byte_cnt_q != 10'd1);
                     state_d    = ST_DATA;
                  end else begin
                     state_d = ST_CRC;
                  end
               end
            end
         end
         ST_DATA: begin
            if (ll_ack) begin
               crc_stb   = 1'b1;
               sr_d      = {1'b0, sr_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (byte_cnt_q != '0) begin
                     sr_d       = hold_q;
                     byte_cnt_d = byte_cnt_q - 10'd1;
                     ack_d      = (byte_cnt_q != 10'd1);
                  end else begin
                     state_d = ST_CRC;
                  end
               end
            end
         end
         ST_CRC: begin
            if (ll_ack) begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (byte_cnt_q[0]) begin
                     byte_cnt_d = '0;
                     done_d     = 1'b1;
                     state_d    = ST_IDLE;
                  end else begin
                     byte_cnt_d = 10'd1;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control registers; reset aborts any packet in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         pid_q      <= '0;
         ll_start_q <= 1'b0;
         ack_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         pid_q      <= pid_d;
         ll_start_q <= ll_start_d;
         ack_q      <= ack_d;
         done_q     <= done_d;
      end
   end

   // Datapath registers; outputs are gated by state so these need no reset.
   always_ff @(posedge clk) begin
      sr_q   <= sr_d;
      hold_q <= hold_d;
   end

   // CRC goes out inverted, register bit 15 first.
   assign crc_idx      = ~{byte_cnt_q[0], bit_cnt_q};
   assign ll_bit       = (state_q == ST_CRC) ? ~crc[crc_idx] : ((state_q != ST_IDLE) & sr_q[0]);
   assign ll_last      = (bit_cnt_q == 3'd7) &&
                         (((state_q == ST_PID) && !is_data) ||
                          ((state_q == ST_CRC) && byte_cnt_q[0]));
   assign ll_start     = ll_start_q;
   assign pkt_data_ack = ack_q;
   assign pkt_done     = done_q;

endmodule
